// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch unit.
//   - Issues single-word reads to instruction memory, with at most one read
//     outstanding at a time.
//   - Buffers the returned words, together with their fetch addresses, in a
//     small in-order queue.
//   - Presents the head of the queue to decode.
//   - A redirect flushes the queue and restarts fetching at a new address.
//   - halt stops new fetches until reset.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   mem_addr     out  16  instruction-memory word address (valid with mem_rd)
//   mem_rd       out  1   one-cycle read request
//   mem_rdata    in   16  returned instruction word
//   mem_valid    in   1   mem_rdata valid, 1+ cycles after mem_rd
//   redirect     in   1   flush queue and refetch from redirect_pc
//   redirect_pc  in   16  new fetch address
//   halt         in   1   stop issuing fetches (sticky until reset)
//   ir           out  16  head-of-queue instruction word
//   ir_pc        out  16  address ir was fetched from
//   ir_valid     out  1   ir / ir_pc valid
//   ir_ready     in   1   decode consumes the head this cycle
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_REQ     | no read outstanding; issue one when a slot is free
// S_WAIT    | read outstanding; its response will be enqueued
// S_DISCARD | read outstanding but stale after a redirect; drop response
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_fetch_pc;
  logic [15:0]     r_req_pc;
  logic            r_halt_q;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [15:0]     r_q_data [DEPTH];
  logic [15:0]     r_q_pc   [DEPTH];

  logic            w_issue;
  logic            w_has;
  logic            w_enq;
  logic            w_deq;

  // Nothing is outstanding in S_REQ, so the count alone decides whether a
  // slot is free for the next response.
  assign w_issue = ~reset & (r_state == S_REQ) & (r_count < CW'(DEPTH)) & ~r_halt_q;
  assign w_has   = (r_count != '0);
  // A redirect kills both the response landing this cycle and any dequeue.
  assign w_enq   = ~reset & (r_state == S_WAIT) & mem_valid & ~redirect;
  assign w_deq   = ~reset & w_has & ir_ready & ~redirect;

  assign mem_rd   = w_issue;
  assign mem_addr = r_fetch_pc;
  assign ir_valid = ~reset & w_has;
  assign ir       = reset ? 16'h0000 : r_q_data[r_head];
  assign ir_pc    = reset ? 16'h0000 : r_q_pc[r_head];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_issue) begin
          w_state_nxt = redirect ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_valid) begin
          w_state_nxt = S_REQ;
        end else if (redirect) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_halt_q   <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_halt_q <= r_halt_q | halt;

      if (w_issue) begin
        r_req_pc <= r_fetch_pc;
      end

      // Redirect wins over the post-issue increment; 16'hFFFF wraps to 0.
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 16'd1;
      end

      if (redirect) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_enq) begin
          r_tail <= r_tail + PW'(1);
        end
        if (w_deq) begin
          r_head <= r_head + PW'(1);
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_data[r_tail] <= mem_rdata;
      r_q_pc[r_tail]   <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, mv;
    logic [15:0] md;
    logic        rdr;
    logic [15:0] rpc;
    logic        hlt, rdy;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_irv;
    logic [15:0] e_ir, e_pc;
  } vec_t;

  vec_t vt [26];

  function automatic vec_t v(input logic rst, mv, input logic [15:0] md, input logic rdr,
                             input logic [15:0] rpc, input logic rdy, e_rd,
                             input logic [15:0] e_addr, input logic e_irv,
                             input logic [15:0] e_ir, e_pc);
    vec_t r;
    r.rst = rst; r.mv = mv; r.md = md; r.rdr = rdr; r.rpc = rpc; r.hlt = 1'b0; r.rdy = rdy;
    r.e_rd = e_rd; r.e_addr = e_addr; r.e_irv = e_irv; r.e_ir = e_ir; r.e_pc = e_pc;
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] data; logic [15:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [15:0] m_pc;
  int          m_out;      // 0: nothing in flight, 1: in flight and wanted, 2: in flight but stale
  logic [15:0] m_out_pc;
  logic        m_halt;

  // memory responder
  logic        mp_pend = 1'b0;
  int          mp_wait = 0;
  logic [15:0] mp_addr = 16'h0;
  int          lat_lo = 1, lat_hi = 1;

  logic s_rd, s_irv;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic step(input logic rst, rdr, input logic [15:0] rpc, input logic hlt, rdy);
    logic e_rd, e_irv;
    logic [15:0] e_addr, e_ir, e_pc;
    logic mv;
    logic [15:0] md;
    reset = rst; redirect = rdr; redirect_pc = rpc; halt = hlt; ir_ready = rdy;
    mv = 1'b0; md = 16'h0;
    if (mp_pend) begin
      if (mp_wait == 0) begin
        mv = 1'b1; md = memf(mp_addr); mp_pend = 1'b0;
      end else begin
        mp_wait--;
      end
    end
    mem_valid = mv; mem_rdata = md;
    @(negedge clk);
    s_rd = mem_rd; s_irv = ir_valid;
    e_addr = m_pc; e_ir = 16'h0; e_pc = 16'h0;
    if (rst) begin
      e_rd = 1'b0; e_irv = 1'b0;
    end else begin
      e_rd  = (m_out == 0) && (m_q.size() < DEPTH) && !m_halt;
      e_irv = (m_q.size() != 0);
      if (e_irv) begin e_ir = m_q[0].data; e_pc = m_q[0].pc; end
    end
    chk("mem_rd", 16'(mem_rd), 16'(e_rd));
    if (e_rd) chk("mem_addr", mem_addr, e_addr);
    chk("ir_valid", 16'(ir_valid), 16'(e_irv));
    if (rst || e_irv) begin
      chk("ir", ir, e_ir);
      chk("ir_pc", ir_pc, e_pc);
    end
    if (e_rd) begin
      mp_pend = 1'b1; mp_wait = int'($urandom_range(lat_hi - 1, lat_lo - 1)); mp_addr = m_pc;
    end
    // model update
    if (rst) begin
      m_q.delete(); m_pc = 16'h0000; m_out = 0; m_halt = 1'b0; m_out_pc = 16'h0;
    end else begin
      if (e_irv && rdy && !rdr) void'(m_q.pop_front());
      if (m_out != 0 && mv) begin
        if (m_out == 1 && !rdr) m_q.push_back('{data: md, pc: m_out_pc});
        m_out = 0;
      end else if (e_rd) begin
        m_out = rdr ? 2 : 1;
        m_out_pc = m_pc;
      end else if (m_out == 1 && rdr) begin
        m_out = 2;
      end
      if (rdr) begin
        m_q.delete(); m_pc = rpc;
      end else if (e_rd) begin
        m_pc = m_pc + 16'd1;
      end
      m_halt = m_halt | hlt;
    end
    @(posedge clk); #1;
  endtask

  int pulses, deqs;
  logic [15:0] last_addr;
  logic reached;

  initial begin
    // table: reset, latency-1 streaming, redirects (WAIT, WAIT+mem_valid, REQ+mem_rd),
    // wrap from FFFF, mid-operation reset with a stale response landing in REQ.
    vt[0]  = v(1,0,16'h0000,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[1]  = v(0,0,16'h0000,0,16'h0000,0, 1,16'h0000, 0,16'h0000,16'h0000);
    vt[2]  = v(0,1,16'h1111,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[3]  = v(0,0,16'h0000,0,16'h0000,1, 1,16'h0001, 1,16'h1111,16'h0000);
    vt[4]  = v(0,1,16'h2222,0,16'h0000,1, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[5]  = v(0,0,16'h0000,0,16'h0000,1, 1,16'h0002, 1,16'h2222,16'h0001);
    vt[6]  = v(0,0,16'h0000,1,16'h0100,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[7]  = v(0,1,16'h3333,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[8]  = v(0,0,16'h0000,0,16'h0000,0, 1,16'h0100, 0,16'h0000,16'h0000);
    vt[9]  = v(0,1,16'h4444,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[10] = v(0,0,16'h0000,0,16'h0000,0, 1,16'h0101, 1,16'h4444,16'h0100);
    vt[11] = v(0,1,16'h5555,1,16'h0200,1, 0,16'h0000, 1,16'h4444,16'h0100);
    vt[12] = v(0,0,16'h0000,0,16'h0000,1, 1,16'h0200, 0,16'h0000,16'h0000);
    vt[13] = v(0,1,16'h6666,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[14] = v(0,0,16'h0000,1,16'hFFFF,0, 1,16'h0201, 1,16'h6666,16'h0200);
    vt[15] = v(0,1,16'h7777,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[16] = v(0,0,16'h0000,0,16'h0000,0, 1,16'hFFFF, 0,16'h0000,16'h0000);
    vt[17] = v(0,1,16'h8888,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[18] = v(0,0,16'h0000,0,16'h0000,1, 1,16'h0000, 1,16'h8888,16'hFFFF);
    vt[19] = v(0,1,16'h9999,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[20] = v(0,0,16'h0000,0,16'h0000,1, 1,16'h0001, 1,16'h9999,16'h0000);
    vt[21] = v(1,0,16'h0000,0,16'h0000,1, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[22] = v(0,1,16'hAAAA,0,16'h0000,0, 1,16'h0000, 0,16'h0000,16'h0000);
    vt[23] = v(0,0,16'h0000,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[24] = v(0,1,16'hBBBB,0,16'h0000,0, 0,16'h0000, 0,16'h0000,16'h0000);
    vt[25] = v(0,0,16'h0000,0,16'h0000,0, 1,16'h0001, 1,16'hBBBB,16'h0000);

    reset = 1'b1; mem_valid = 1'b0; mem_rdata = 16'h0; redirect = 1'b0;
    redirect_pc = 16'h0; halt = 1'b0; ir_ready = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      reset = vt[i].rst; mem_valid = vt[i].mv; mem_rdata = vt[i].md; redirect = vt[i].rdr;
      redirect_pc = vt[i].rpc; halt = vt[i].hlt; ir_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d mem_rd", i), 16'(mem_rd), 16'(vt[i].e_rd));
      if (vt[i].e_rd) chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d ir_valid", i), 16'(ir_valid), 16'(vt[i].e_irv));
      if (vt[i].e_irv || vt[i].rst) begin
        chk($sformatf("vec%0d ir", i), ir, vt[i].e_ir);
        chk($sformatf("vec%0d ir_pc", i), ir_pc, vt[i].e_pc);
      end
      @(posedge clk); #1;
    end

    // queue fills to DEPTH with decode stalled, then one dequeue frees one fetch
    mp_pend = 1'b0; lat_lo = 1; lat_hi = 1;
    step(1, 0, 16'h0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 16'h0, 0, 0);
      if (s_rd) pulses++;
    end
    chk("fill fetch count", 16'(pulses), 16'(DEPTH));
    step(0, 0, 16'h0, 0, 1);
    pulses = 0; last_addr = 16'h0;
    for (int i = 0; i < 10; i++) begin
      reset = 1'b0;
      step(0, 0, 16'h0, 0, 0);
      if (s_rd) begin pulses++; last_addr = m_out_pc; end
    end
    chk("refill fetch count", 16'(pulses), 16'd1);
    chk("refill fetch addr", last_addr, 16'h0004);

    // halt while a third read is outstanding
    lat_lo = 2; lat_hi = 2;
    step(1, 0, 16'h0, 0, 0);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step(0, 0, 16'h0, 0, 0);
      reached = (m_q.size() == 2) && (m_out == 1);
    end
    chk("halt setup reached", 16'(reached), 16'd1);
    step(0, 0, 16'h0, 1, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 16'h0, 0, 0);
      if (s_rd) pulses++;
    end
    chk("halt no fetch", 16'(pulses), 16'd0);
    deqs = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 16'h0, 0, 1);
      if (s_irv) deqs++;
      if (s_rd) pulses++;
    end
    chk("halt drain count", 16'(deqs), 16'd3);
    chk("halt no fetch after drain", 16'(pulses), 16'd0);
    chk("halt drained ir_valid", 16'(ir_valid), 16'd0);

    // randomized run against the model
    lat_lo = 1; lat_hi = 4;
    step(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic rr, hh, rs;
      logic [15:0] pc;
      rs = ($urandom_range(299, 0) == 0);
      rr = ($urandom_range(15, 0) == 0);
      hh = ($urandom_range(399, 0) == 0);
      pc = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
      step(rs, rr, pc, hh, 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch-queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 16'h0000, fetch address after reset.
REQ-003 One clock; reset is synchronous and active-high: port clk, input, 1, rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 mem_addr  output  16  instruction-memory word address.
REQ-006 mem_rd  output  1  one-cycle read request; mem_addr is valid while high.
REQ-007 mem_rdata  input  16  instruction word returned by memory.
REQ-008 mem_valid  input  1  mem_rdata valid; arrives 1+ cycles after mem_rd, never in the mem_rd cycle.
REQ-009 redirect  input  1  decode has taken a jump/branch; flush and refetch.
REQ-010 redirect_pc  input  16  new fetch address, sampled when redirect=1.
REQ-011 halt  input  1  stop issuing fetches; sticky until reset.
REQ-012 ir  output  16  head-of-queue instruction word.
REQ-013 ir_pc  output  16  address ir was fetched from.
REQ-014 ir_valid  output  1  ir/ir_pc valid.
REQ-015 ir_ready  input  1  decode consumes head this cycle.

Function
REQ-016 State machine SHALL have states REQ, WAIT, DISCARD.
REQ-017 mem_rd = (state==REQ) & (count + 0 outstanding < DEPTH) & ~halt_q; mem_addr = fetch_pc.
REQ-018 REQ: on mem_rd, fetch_pc <= fetch_pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000), go to WAIT; otherwise stay in REQ.
REQ-019 At most one memory request SHALL be outstanding.
REQ-020 WAIT: on mem_valid, enqueue {mem_rdata, request address}, go to REQ; otherwise stay.
REQ-021 DISCARD: on mem_valid, drop the data, go to REQ; otherwise stay.
REQ-022 A request is issued only when a free slot exists, so an enqueue never overflows.
REQ-023 ir_valid = (count != 0); ir/ir_pc = head entry; dequeue when ir_valid & ir_ready.
REQ-024 Latency: mem_valid at edge N -> ir_valid high in cycle N+1 if the queue was empty; no bypass.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged, preserving order.
REQ-026 Any cycle with redirect=1: queue flushed (count <= 0), fetch_pc <= redirect_pc, and any dequeue that cycle is ignored.
REQ-027 Redirect in WAIT without mem_valid, or in REQ with mem_rd=1 -> DISCARD.
REQ-028 Redirect in WAIT with mem_valid same cycle -> response dropped, go to REQ.
REQ-029 Redirect in REQ with mem_rd=0, or in DISCARD -> state unchanged (DISCARD still drops one response).
REQ-030 halt sets halt_q at the next edge; an outstanding response still completes per WAIT/DISCARD; queued entries remain dequeuable; redirect still updates fetch_pc and flushes.
REQ-031 First mem_rd SHALL assert in the first cycle after reset deasserts, with mem_addr=RESET_PC.

Reset
REQ-032 On reset: state=REQ, fetch_pc=RESET_PC, count=0, head/tail pointers=0, halt_q=0.
REQ-033 During reset: mem_rd=0, ir_valid=0, ir=16'h0000, ir_pc=16'h0000.
REQ-034 Reset asserted mid-operation SHALL override all other inputs; a later mem_valid for a pre-reset request arriving in REQ SHALL be ignored.

Verification
REQ-035 Reset release, memory latency 1, ir_ready=1 -> mem_addr 0,1,2,... every 2 cycles; ir/ir_pc pairs match memory contents in order.
REQ-036 ir_ready=0, DEPTH=4 -> exactly 4 fetches (0..3), then mem_rd stays 0; raising ir_ready for one cycle -> one more fetch at address 4.
REQ-037 Redirect to 16'h0100 while WAIT on address 2 -> response for 2 dropped, queue empty next cycle, next mem_addr=16'h0100, first ir_pc=16'h0100.
REQ-038 Redirect coinciding with mem_valid and ir_ready -> neither enqueued nor dequeued; count=0; next fetch at redirect_pc.
REQ-039 redirect_pc=16'hFFFF -> fetches FFFF, then 0000; ir_pc sequence FFFF, 0000.
REQ-040 halt during WAIT with 2 entries queued -> outstanding word enqueued (count=3), no further mem_rd, 3 entries drain with ir_ready=1, then ir_valid=0.
